// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

  localparam int unsigned SHIFT_OP_W = 3;

  // Operation encoding; codes 5..7 are reserved and pass data through unchanged.
  typedef enum logic [SHIFT_OP_W-1:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_op_e;

  // True for operations that move bits toward the LSB.
  function automatic logic is_right(input logic [SHIFT_OP_W-1:0] op);
    return (op == SRL) || (op == SRA) || (op == ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One log stage of the barrel shifter: shifts/rotates by the fixed amount
// SHAMT when enabled, otherwise passes the operand through. Purely combinational.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHAMT = 1
) (
  input  logic                  i_en,
  input  logic [SHIFT_OP_W-1:0] i_op,
  input  logic                  i_sign,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_data
);

  // Select the shifted form of the operand for this stage's fixed distance.
  // SRA fills with the sign of the original operand, carried alongside the data,
  // because earlier stages may already have moved the current MSB.
  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_op)
        SLL:     o_data = i_data << SHAMT;
        SRL:     o_data = i_data >> SHAMT;
        SRA:     o_data = {{SHAMT{i_sign}}, i_data[WIDTH-1:SHAMT]};
        ROL:     o_data = {i_data[WIDTH-1-SHAMT:0], i_data[WIDTH-1:WIDTH-SHAMT]};
        ROR:     o_data = {i_data[SHAMT-1:0], i_data[WIDTH-1:SHAMT]};
        default: o_data = i_data;
      endcase
    end else begin
      o_data = i_data;
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Parametrised log-stage barrel shifter (SLL/SRL/SRA/ROL/ROR) with optional
// pipeline registers after selected stages and a valid/ready handshake.
// Each registered boundary is a one-entry slice that advances when empty or
// when its successor accepts, giving full throughput and in-order delivery.
module pipe_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned   WIDTH      = 64,
  parameter logic [31:0]   REG_STAGES = 32'b010101,
  parameter int unsigned   TAG_W      = 4,
  localparam int unsigned  SHAMT_W    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SHAMT_W-1:0]    in_shamt,
  input  logic [SHIFT_OP_W-1:0] in_op,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag
);

  // Everything that travels down the pipe with one operation.
  typedef struct packed {
    logic [WIDTH-1:0]      data;
    logic [SHAMT_W-1:0]    shamt;
    logic [SHIFT_OP_W-1:0] op;
    logic                  sign;
    logic [TAG_W-1:0]      tag;
  } beat_t;

  beat_t w_head;
  logic  w_unused_tail;

  assign w_head = '{data: in_data, shamt: in_shamt, op: in_op,
                    sign: in_data[WIDTH-1], tag: in_tag};

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_st
    beat_t            w_in;
    beat_t            w_shifted;
    beat_t            w_out;
    logic [WIDTH-1:0] w_sdata;
    logic             w_v_in;
    logic             w_v_out;
    logic             w_rdy_in;
    logic             w_rdy_out;

    if (k == 0) begin : g_src
      assign w_in   = w_head;
      assign w_v_in = in_valid;
    end else begin : g_src
      assign w_in   = g_st[k-1].w_out;
      assign w_v_in = g_st[k-1].w_v_out;
    end

    if (k == SHAMT_W - 1) begin : g_snk
      assign w_rdy_out = out_ready;
    end else begin : g_snk
      assign w_rdy_out = g_st[k+1].w_rdy_in;
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .SHAMT (32'd1 << k)
    ) u_stage (
      .i_en   (w_in.shamt[k]),
      .i_op   (w_in.op),
      .i_sign (w_in.sign),
      .i_data (w_in.data),
      .o_data (w_sdata)
    );

    assign w_shifted = '{data: w_sdata, shamt: w_in.shamt, op: w_in.op,
                         sign: w_in.sign, tag: w_in.tag};

    if (REG_STAGES[k]) begin : g_pipe
      logic  r_valid;
      beat_t r_beat;

      assign w_rdy_in = ~r_valid | w_rdy_out;
      assign w_v_out  = r_valid;
      assign w_out    = r_beat;

      // Load a new beat when the slot is empty or its occupant moves on; hold otherwise.
      // The payload is reset too, so out_data/out_tag read zero from reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_beat  <= '0;
        end else if (w_rdy_in) begin
          r_valid <= w_v_in;
          if (w_v_in) begin
            r_beat <= w_shifted;
          end
        end
      end
    end else begin : g_pipe
      assign w_rdy_in = w_rdy_out;
      assign w_v_out  = w_v_in;
      assign w_out    = w_shifted;
    end
  end

  assign in_ready  = g_st[0].w_rdy_in;
  assign out_valid = g_st[SHAMT_W-1].w_v_out;
  assign out_data  = g_st[SHAMT_W-1].w_out.data;
  assign out_tag   = g_st[SHAMT_W-1].w_out.tag;

  // Control fields are spent once the last stage has been applied.
  assign w_unused_tail = ^{g_st[SHAMT_W-1].w_out.shamt,
                           g_st[SHAMT_W-1].w_out.op,
                           g_st[SHAMT_W-1].w_out.sign};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter: directed spec cases, a stall
// scenario, mid-stream reset, a zero-latency instance and randomized traffic
// scored against a plain-arithmetic reference model.
module tb_pipe_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_shamt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_tag;

  logic        in_ready0;
  logic        out_valid0;
  logic [63:0] out_data0;
  logic [3:0]  out_tag0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  bit   acc;
  bit   ret;

  always #5 clk = ~clk;

  pipe_barrel_shifter #(.WIDTH(64), .REG_STAGES(32'b010101), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  pipe_barrel_shifter #(.WIDTH(64), .REG_STAGES(32'd0), .TAG_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_tag(out_tag0)
  );

  // Reference: whole-amount shift/rotate with ordinary operators.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] d, input int s);
    logic [127:0] dd;
    dd = {d, d};
    case (op)
      3'd0: return d << s;
      3'd1: return d >> s;
      3'd2: return 64'($signed(d) >>> s);
      3'd3: begin dd = dd << s; return dd[127:64]; end
      3'd4: begin dd = dd >> s; return dd[63:0];   end
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  // One cycle: score outputs, log accepted inputs, advance to just after the next edge.
  task automatic tick(output bit a, output bit r);
    exp_t e;
    #2;
    a = in_valid && in_ready;
    r = out_valid && out_ready;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        check("out_data", out_data, sb[0].data);
        check("out_tag", {60'd0, out_tag}, {60'd0, sb[0].tag});
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (a) begin
      e.data = model(in_op, in_data, int'(in_shamt));
      e.tag  = in_tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Single isolated operation with latency measurement.
  task automatic single(input string tag, input logic [2:0] op, input logic [63:0] d,
                        input logic [5:0] sh, input logic [63:0] exp, input logic [3:0] tg);
    int lat;
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tg; out_ready = 1'b1;
    #2;
    check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_tag"}, {60'd0, out_tag}, {60'd0, tg});
    @(posedge clk); #1;
    check({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int i;
    int first_block;
    int retired;
    int last_ret;

    // Reset state
    rst_n = 1'b1; in_valid = 1'b0; in_data = 64'd0; in_shamt = 6'd0; in_op = 3'd0;
    in_tag = 4'd0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    single("t1_sll63", 3'd0, 64'h1, 6'd63, 64'h8000_0000_0000_0000, 4'd1);
    single("t2_sra4", 3'd2, 64'h8000_0000_0000_0000, 6'd4, 64'hF800_0000_0000_0000, 4'd2);
    single("t2_srl4", 3'd1, 64'h8000_0000_0000_0000, 6'd4, 64'h0800_0000_0000_0000, 4'd3);
    single("t3_ror1", 3'd4, 64'h1, 6'd1, 64'h8000_0000_0000_0000, 4'd4);
    single("t3_rol4", 3'd3, 64'h8000_0000_0000_0001, 6'd4, 64'h18, 4'd5);
    for (int op = 0; op < 5; op++)
      single("t5_sh0", 3'(op), 64'hDEAD_BEEF_0123_4567, 6'd0, 64'hDEAD_BEEF_0123_4567, 4'(op));
    single("t5_rsv7", 3'd7, 64'hDEAD_BEEF_0123_4567, 6'd17, 64'hDEAD_BEEF_0123_4567, 4'd9);
    single("t5_rsv5", 3'd5, 64'hDEAD_BEEF_0123_4567, 6'd17, 64'hDEAD_BEEF_0123_4567, 4'd10);

    // Back-to-back 8 ops with downstream stall on cycles 2..7
    i = 0; first_block = -1; retired = 0; last_ret = -1;
    for (int c = 0; c < 40; c++) begin
      if (i >= 8 && sb.size() == 0) break;
      in_valid = (i < 8);
      if (i < 8) begin
        in_op = 3'(i % 5); in_data = {$urandom(), $urandom()};
        in_shamt = 6'((i * 7) % 64); in_tag = 4'(i);
      end
      out_ready = !(c >= 2 && c <= 7);
      tick(acc, ret);
      if (acc) i++;
      if (in_valid && !acc && first_block < 0) begin
        first_block = c;
        check("t4_held_at_block", 64'(i), 64'd3);
      end
      if (ret) begin
        retired++;
        last_ret = c;
      end
    end
    in_valid = 1'b0;
    check("t4_first_block", 64'(first_block), 64'd3);
    check("t4_accepted", 64'(i), 64'd8);
    check("t4_retired", 64'(retired), 64'd8);
    check("t4_last_retire", 64'(last_ret), 64'd15);

    // Reset with three operations in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_op = 3'd3; in_data = {$urandom(), $urandom()} | 64'h1; in_shamt = 6'(c + 1);
      in_tag = 4'(c + 1);
      tick(acc, ret);
    end
    in_valid = 1'b0;
    check("t6_full_valid", {63'd0, out_valid}, 64'd1);
    check("t6_full_block", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_data", out_data, 64'd0);
    check("t6_rst_tag", {60'd0, out_tag}, 64'd0);
    check("t6_rst_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      check("t6_no_stale", {63'd0, out_valid}, 64'd0);
      tick(acc, ret);
    end

    // Zero-latency instance: combinational path and direct ready
    in_valid = 1'b1; in_op = 3'd0; in_data = 64'h1; in_shamt = 6'd63; in_tag = 4'd6;
    out_ready = 1'b1;
    #1;
    check("l0_valid", {63'd0, out_valid0}, 64'd1);
    check("l0_data", out_data0, 64'h8000_0000_0000_0000);
    check("l0_tag", {60'd0, out_tag0}, 64'd6);
    check("l0_ready_hi", {63'd0, in_ready0}, 64'd1);
    out_ready = 1'b0;
    #1;
    check("l0_ready_lo", {63'd0, in_ready0}, 64'd0);
    in_valid = 1'b0;
    #1;
    check("l0_valid_lo", {63'd0, out_valid0}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    sb.delete();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      in_op     = 3'($urandom_range(7, 0));
      in_data   = {$urandom(), $urandom()};
      in_shamt  = 6'($urandom_range(63, 0));
      in_tag    = 4'($urandom_range(15, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      tick(acc, ret);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick(acc, ret);
    check("rand_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
